// File: rtl/p45_writeback.sv
// Memory-access and register-writeback stage of the SIMPLE 16-bit processor.
// ALU ops retire in one cycle; loads/stores stall in MEM until ack or timeout.
module p45_writeback #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] aluresult,
  input  logic        writereg,
  input  logic [1:0]  memwrite,
  input  logic [2:0]  regaddress,
  input  logic [15:0] address,
  input  logic [15:0] storedata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        writeflag,
  output logic [2:0]  writetarget,
  output logic [15:0] writeval,
  output logic [15:0] retired,
  output logic        err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    MEM  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_nextState;

  logic          r_memReq;
  logic          r_memWe;
  logic [15:0]   r_memAddr;
  logic [15:0]   r_memWdata;
  logic          r_writeflag;
  logic [2:0]    r_writetarget;
  logic [15:0]   r_writeval;
  logic [15:0]   r_retired;
  logic          r_err;
  logic          r_wbEn;
  logic [2:0]    r_wbReg;
  logic [CW-1:0] r_waitCnt;

  logic          w_isMem;
  logic          w_accept;
  logic          w_aluAccept;
  logic          w_memAccept;
  logic          w_ack;
  logic          w_timeout;

  always_comb begin
    w_isMem     = (memwrite == 2'b01) || (memwrite == 2'b10);
    w_accept    = (r_state == IDLE) && in_valid;
    w_aluAccept = w_accept && !w_isMem;
    w_memAccept = w_accept && w_isMem;
    w_ack       = (r_state == MEM) && mem_ack;
    // The ack takes priority, so a timeout only fires on an edge without ack.
    w_timeout   = (r_state == MEM) && !mem_ack && (r_waitCnt == CW'(TIMEOUT - 1));
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_memAccept) w_nextState = MEM;
      MEM:     if (w_ack || w_timeout) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_memReq      <= 1'b0;
      r_memWe       <= 1'b0;
      r_memAddr     <= '0;
      r_memWdata    <= '0;
      r_writeflag   <= 1'b0;
      r_writetarget <= '0;
      r_writeval    <= '0;
      r_retired     <= '0;
      r_err         <= 1'b0;
      r_wbEn        <= 1'b0;
      r_wbReg       <= '0;
      r_waitCnt     <= '0;
    end else begin
      r_writeflag <= 1'b0;
      if (w_aluAccept) begin
        r_writeflag   <= writereg;
        r_writetarget <= regaddress;
        r_writeval    <= aluresult;
        r_retired     <= r_retired + 16'd1;
      end else if (w_memAccept) begin
        r_memReq   <= 1'b1;
        r_memWe    <= (memwrite == 2'b10);
        r_memAddr  <= address;
        r_memWdata <= storedata;
        r_wbEn     <= writereg;
        r_wbReg    <= regaddress;
        r_waitCnt  <= '0;
      end else if (w_ack) begin
        r_memReq  <= 1'b0;
        r_retired <= r_retired + 16'd1;
        if (!r_memWe) begin
          r_writeflag   <= r_wbEn;
          r_writetarget <= r_wbReg;
          r_writeval    <= mem_rdata;
        end
      end else if (r_state == MEM) begin
        r_waitCnt <= r_waitCnt + 1'b1;
        if (w_timeout) begin
          r_memReq <= 1'b0;
          r_err    <= 1'b1;
        end
      end
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign mem_req     = r_memReq;
  assign mem_we      = r_memWe;
  assign mem_addr    = r_memAddr;
  assign mem_wdata   = r_memWdata;
  assign writeflag   = r_writeflag;
  assign writetarget = r_writetarget;
  assign writeval    = r_writeval;
  assign retired     = r_retired;
  assign err         = r_err;

endmodule

// File: tb/tb_p45_writeback.sv
// Scoreboard bench for p45_writeback: stimulus pushes expected register writes,
// a negedge monitor pops and compares them whenever writeflag is seen.
module tb_p45_writeback;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] aluresult;
  logic        writereg;
  logic [1:0]  memwrite;
  logic [2:0]  regaddress;
  logic [15:0] address;
  logic [15:0] storedata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        writeflag;
  logic [2:0]  writetarget;
  logic [15:0] writeval;
  logic [15:0] retired;
  logic        err;

  typedef struct packed {
    logic [2:0]  tgt;
    logic [15:0] val;
    logic [15:0] ret;
  } exp_t;

  exp_t        sbQ[$];
  logic [15:0] expRet;
  int          nChecks = 0;
  int          nFails  = 0;

  p45_writeback #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .aluresult(aluresult), .writereg(writereg), .memwrite(memwrite),
    .regaddress(regaddress), .address(address), .storedata(storedata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .writeflag(writeflag),
    .writetarget(writetarget), .writeval(writeval), .retired(retired), .err(err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] mw, input logic [15:0] alu,
                               input logic wr, input logic [2:0] ra,
                               input logic [15:0] addr, input logic [15:0] sd);
    in_valid   = v;
    memwrite   = mw;
    aluresult  = alu;
    writereg   = wr;
    regaddress = ra;
    address    = addr;
    storedata  = sd;
  endtask

  task automatic pushExp(input logic [2:0] tgt, input logic [15:0] val);
    expRet = expRet + 16'd1;
    sbQ.push_back(exp_t'{tgt, val, expRet});
  endtask

  // Called right after a memory op is presented; walks n MEM cycles checking the
  // request stays stable, optionally acking on the last one.
  task automatic memWait(input int n, input logic ack, input logic [15:0] rdata,
                         input logic expWe, input logic [15:0] expAddr,
                         input logic [15:0] expWdata, input logic holdValid, input string tag);
    @(negedge clock);
    if (holdValid) applyStimulus(1'b1, 2'b00, 16'hDEAD, 1'b1, 3'd7, 16'h0, 16'h0);
    else           in_valid = 1'b0;
    for (int i = 1; i <= n; i++) begin
      checkOutput({tag, "_mem_req_high"}, mem_req, 1);
      checkOutput({tag, "_in_ready_low"}, in_ready, 0);
      checkOutput({tag, "_mem_we"}, mem_we, expWe);
      checkOutput({tag, "_mem_addr"}, mem_addr, expAddr);
      if (expWe) checkOutput({tag, "_mem_wdata"}, mem_wdata, expWdata);
      if (i == n && ack) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clock);
      in_valid = 1'b0;
    end
    mem_ack = 1'b0;
    checkOutput({tag, "_mem_req_low"}, mem_req, 0);
    checkOutput({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  always @(negedge clock) begin
    if (writeflag === 1'b1) begin
      nChecks++;
      if (sbQ.size() == 0) begin
        nFails++;
        $display("[TB] FAIL unexpected_write: got tgt=%0d val=%h ret=%h, required no write",
                 writetarget, writeval, retired);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        if ({writetarget, writeval, retired} !== e) begin
          nFails++;
          $display("[TB] FAIL writeback: got tgt=%0d val=%h ret=%h, required tgt=%0d val=%h ret=%h",
                   writetarget, writeval, retired, e.tgt, e.val, e.ret);
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    expRet    = 16'h0;
    applyStimulus(1'b0, 2'b00, 16'h0, 1'b0, 3'd0, 16'h0, 16'h0);
    repeat (2) @(negedge clock);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_writeflag", writeflag, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_retired", retired, 0);
    checkOutput("rst_writeval", writeval, 0);
    checkOutput("rst_writetarget", writetarget, 0);
    reset = 1'b0;

    // ALU op retires in one cycle
    applyStimulus(1'b1, 2'b00, 16'h1234, 1'b1, 3'd5, 16'h0, 16'h0);
    pushExp(3'd5, 16'h1234);
    @(negedge clock);
    in_valid = 1'b0;
    checkOutput("alu_writeflag", writeflag, 1);
    checkOutput("alu_retired", retired, expRet);
    @(negedge clock);
    checkOutput("alu_writeflag_clear", writeflag, 0);

    // Load acked on the third MEM edge
    applyStimulus(1'b1, 2'b01, 16'h0, 1'b1, 3'd3, 16'h00F0, 16'h0);
    pushExp(3'd3, 16'hBEEF);
    memWait(3, 1'b1, 16'hBEEF, 1'b0, 16'h00F0, 16'h0, 1'b0, "load");
    checkOutput("load_writeflag", writeflag, 1);

    // Store with immediate ack while in_valid stays high during MEM
    @(negedge clock);
    applyStimulus(1'b1, 2'b10, 16'h0, 1'b1, 3'd6, 16'h0010, 16'hA5A5);
    expRet = expRet + 16'd1;
    memWait(1, 1'b1, 16'h0, 1'b1, 16'h0010, 16'hA5A5, 1'b1, "store");
    checkOutput("store_no_write", writeflag, 0);
    checkOutput("store_retired", retired, expRet);
    @(negedge clock);
    checkOutput("store_retired_hold", retired, expRet);

    // Load with no ack times out after exactly TIMEOUT cycles
    applyStimulus(1'b1, 2'b01, 16'h0, 1'b1, 3'd1, 16'h0020, 16'h0);
    memWait(4, 1'b0, 16'h0, 1'b0, 16'h0020, 16'h0, 1'b0, "timeout");
    checkOutput("timeout_err", err, 1);
    checkOutput("timeout_no_write", writeflag, 0);
    checkOutput("timeout_retired", retired, expRet);
    applyStimulus(1'b1, 2'b11, 16'h5555, 1'b1, 3'd2, 16'h0, 16'h0);
    pushExp(3'd2, 16'h5555);
    @(negedge clock);
    in_valid = 1'b0;
    checkOutput("err_sticky", err, 1);
    checkOutput("op11_retired", retired, expRet);

    reset = 1'b1;
    @(negedge clock);
    reset  = 1'b0;
    expRet = 16'h0;
    checkOutput("rst2_err", err, 0);
    checkOutput("rst2_retired", retired, 0);

    // Ack arriving on the edge the timeout would fire
    applyStimulus(1'b1, 2'b01, 16'h0, 1'b1, 3'd2, 16'h0040, 16'h0);
    pushExp(3'd2, 16'hCAFE);
    memWait(4, 1'b1, 16'hCAFE, 1'b0, 16'h0040, 16'h0, 1'b0, "ackrace");
    checkOutput("ackrace_err", err, 0);
    checkOutput("ackrace_retired", retired, expRet);
    @(negedge clock);

    // Reset in the middle of a memory access
    applyStimulus(1'b1, 2'b01, 16'h0, 1'b1, 3'd4, 16'h0080, 16'h0);
    @(negedge clock);
    in_valid = 1'b0;
    checkOutput("midrst_mem_req_before", mem_req, 1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midrst_mem_req", mem_req, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_mem_addr", mem_addr, 0);
    checkOutput("midrst_writeval", writeval, 0);
    checkOutput("midrst_writetarget", writetarget, 0);
    checkOutput("midrst_retired", retired, 0);
    checkOutput("midrst_writeflag", writeflag, 0);
    reset  = 1'b0;
    expRet = 16'h0;

    // 65536 back-to-back ALU ops wrap the retire counter
    for (int i = 0; i < 65536; i++) begin
      applyStimulus(1'b1, 2'b00, 16'(i), 1'b1, 3'(i), 16'h0, 16'h0);
      pushExp(3'(i), 16'(i));
      @(negedge clock);
      if (i == 0 || i == 65535) checkOutput("wrap_writeflag", writeflag, 1);
    end
    in_valid = 1'b0;
    checkOutput("wrap_retired", retired, 16'h0000);
    @(negedge clock);
    checkOutput("wrap_writeflag_clear", writeflag, 0);
    checkOutput("scoreboard_drained", sbQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/p45_writeback.md
# p45_writeback

Memory-access and register-writeback stage of the SIMPLE 16-bit processor. Consumes the decoded control bundle and the ALU result from the decode/execute stages, performs the single data-memory load or store through a request/acknowledge port, and drives the register-file write port (`writeflag`/`writetarget`/`writeval`) back to the decode stage. Non-memory instructions complete in one cycle. Memory instructions stall the stage until the memory acknowledges or a timeout fires.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum number of cycles spent in MEM waiting for `mem_ack` before the access is aborted.

Ports:
- `clock` input 1: the only clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: an instruction bundle is presented.
- `in_ready` output 1: stage can accept; equals (state == IDLE).
- `aluresult` input 16: ALU output for the instruction.
- `writereg` input 1: instruction writes a register.
- `memwrite` input 2: 00 no memory access, 01 load, 10 store, 11 treated as 00.
- `regaddress` input 3: destination register.
- `address` input 16: data-memory address.
- `storedata` input 16: data to store.
- `mem_req` output 1: memory request, held until acknowledged or timed out.
- `mem_we` output 1: 1 = store, 0 = load.
- `mem_addr` output 16: latched `address`.
- `mem_wdata` output 16: latched `storedata`.
- `mem_rdata` input 16: load data, valid in the cycle `mem_ack` = 1.
- `mem_ack` input 1: single-cycle acknowledge.
- `writeflag` output 1: register-file write strobe, one cycle per write.
- `writetarget` output 3: register written.
- `writeval` output 16: value written.
- `retired` output 16: count of completed instructions.
- `err` output 1: sticky memory-timeout flag.

## Operation
- States: IDLE and MEM. An instruction is accepted at an edge where state == IDLE and `in_valid` = 1.
- Accept with `memwrite` = 00 or 11:
  - `writeflag`<=`writereg`, `writetarget`<=`regaddress`, `writeval`<=`aluresult`.
  - `retired`++.
  - State stays IDLE.
- Accept with 01 or 10:
  - `mem_req`<=1, `mem_we`<=(`memwrite`==10), `mem_addr`<=`address`, `mem_wdata`<=`storedata`.
  - Latch `writereg` and `regaddress`. Wait counter <=0. State<=MEM.
- MEM, edge with `mem_ack` = 1:
  - `mem_req`<=0, `retired`++, state<=IDLE.
  - Load: `writeflag`<=latched `writereg`, `writetarget`<=latched `regaddress`, `writeval`<=`mem_rdata`.
  - Store: no register write.
- MEM, edge with `mem_ack` = 0:
  - Counter++.
  - If the counter has reached `TIMEOUT`-1: `mem_req`<=0, `err`<=1, no writeback, no retire, state<=IDLE.
- `mem_ack` and timeout on the same edge: the ack wins.
- `writeflag` is cleared on every edge that does not set it, so it is a one-cycle strobe. `writetarget` and `writeval` hold their last values.
- `mem_ack` received in IDLE is ignored. `in_valid` received in MEM is ignored; the upstream stage holds the bundle.
- `retired` wraps from 0xFFFF to 0x0000. `err` is cleared only by reset.
- Reset values:
  - `mem_req`, `mem_we`, `writeflag`, `err` = 0.
  - `mem_addr`, `mem_wdata`, `writeval`, `retired` = 0.
  - `writetarget` = 0. State = IDLE, so `in_ready` = 1.
- Reset during MEM drops `mem_req` at that edge and discards the instruction, with no writeback and no retire.

## Timing
- Non-memory op accepted at edge k: `writeflag` is high in cycle k..k+1, and `retired` is updated in the same cycle. Throughput is 1 instruction per cycle.
- Memory op accepted at edge k: `mem_req` rises after edge k and `in_ready` falls at the same time.
- Ack sampled at edge k+n (n≥1): `mem_req` falls, `in_ready` rises and, for a load, `writeflag` pulses, all after edge k+n. The next instruction can be accepted at edge k+n+1.
- Timeout: with no ack, `mem_req` stays high for exactly `TIMEOUT` cycles, then `err` rises.
- `mem_addr`, `mem_we` and `mem_wdata` stay stable for the whole time `mem_req` is high.

## Test plan
- Reset, then ALU op `aluresult`=0x1234, `regaddress`=5, `writereg`=1 → next cycle `writeflag`=1, `writetarget`=5, `writeval`=0x1234, `retired`=1. One cycle later `writeflag`=0.
- Load, `address`=0x00F0, `regaddress`=3; ack after 3 cycles with `mem_rdata`=0xBEEF → `mem_req` high for 3 cycles with `mem_we`=0 and `mem_addr`=0x00F0. Then a `writeflag` pulse with target 3, value 0xBEEF; `in_ready` back to 1.
- Store, `address`=0x0010, `storedata`=0xA5A5, immediate ack → `mem_we`=1, `mem_wdata`=0xA5A5, no `writeflag`, `retired` increments. `in_valid` asserted during MEM is not accepted.
- Load with no ack, `TIMEOUT`=4 → `mem_req` high for exactly 4 cycles, then `err`=1, no writeback, `retired` unchanged. `err` stays 1 across later ops until reset.
- Ack in the same cycle the timeout would fire → load completes normally and `err` stays 0. Reset asserted mid-MEM → `mem_req`=0 and every output returns to its reset value the next cycle.
- 65,536 back-to-back ALU ops → `retired` wraps to 0x0000 and `writeflag` is high every cycle.
